// File: rtl/riscv_fetch_queue.sv
// riscv_fetch_queue: instruction prefetch buffer between instruction memory and the IF stage.
//
// Issues word-aligned fetches with at most one granted-but-unanswered request and stores
// responses in a DEPTH-entry FIFO. Branches and hardware-loop redirects flush the FIFO. A
// response belonging to a flushed stream is dropped.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   req_i              fetch enable from the IF stage
//   branch_i, addr_i   redirect the fetch stream to addr_i (addr_i[1:0] ignored)
//   hwloop_i           head entry is the last instruction of a hardware loop
//   hwloop_target_i    loop start address used when the head with hwloop_i is consumed
//   ready_i            consumer accepts the head entry
//   valid_o, rdata_o, addr_o, is_hwlp_o   head entry of the FIFO
//   instr_req_o, instr_addr_o, instr_gnt_i, instr_rvalid_i, instr_rdata_i   memory port
//   busy_o             request in flight or FIFO non-empty
module riscv_fetch_queue #(
    parameter int unsigned DEPTH = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    input  logic        branch_i,
    input  logic [31:0] addr_i,
    input  logic        hwloop_i,
    input  logic [31:0] hwloop_target_i,
    input  logic        ready_i,
    output logic        valid_o,
    output logic [31:0] rdata_o,
    output logic [31:0] addr_o,
    output logic        is_hwlp_o,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    output logic        busy_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {StIdle, StWaitGnt, StWaitRvalid, StWaitAborted} state_e;

    state_e                 state_q, state_d;
    // Address/flag of the pending or outstanding request; in StIdle the next fetch address,
    // in StWaitAborted the saved redirect target.
    logic [31:0]            fetch_addr_q, fetch_addr_d;
    logic                   fetch_hwlp_q, fetch_hwlp_d;
    logic [CntW-1:0]        count_q, count_d;
    logic [PtrW-1:0]        rptr_q, rptr_d, wptr_q, wptr_d;
    logic [DEPTH-1:0][31:0] mem_rdata_q;
    logic [DEPTH-1:0][31:0] mem_addr_q;
    logic [DEPTH-1:0]       mem_hwlp_q;

    logic        pop, push, issue;
    logic        hw_redir, redir, redir_hwlp;
    logic        space_idle, space_b2b;
    logic [31:0] redir_addr, next_addr;
    logic        next_hwlp;

    // Read side: a branch masks the head in the cycle it flushes the FIFO.
    assign valid_o   = (count_q != '0) && !branch_i;
    assign rdata_o   = mem_rdata_q[rptr_q];
    assign addr_o    = mem_addr_q[rptr_q];
    assign is_hwlp_o = mem_hwlp_q[rptr_q];
    assign pop       = valid_o && ready_i;
    assign busy_o    = (state_q != StIdle) || (count_q != '0);

    // Branch wins over a simultaneous loop-end redirect.
    assign hw_redir   = pop && hwloop_i;
    assign redir      = branch_i || hw_redir;
    assign redir_hwlp = !branch_i;
    assign redir_addr = branch_i ? {addr_i[31:2], 2'b00} : {hwloop_target_i[31:2], 2'b00};

    // In StWaitRvalid the outstanding word is counted as already in the FIFO.
    assign space_idle = 32'(count_q) < DEPTH;
    assign space_b2b  = (32'(count_q) + 32'd1) < DEPTH;

    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        fetch_hwlp_d = fetch_hwlp_q;
        issue        = 1'b0;
        push         = 1'b0;
        next_addr    = fetch_addr_q;
        next_hwlp    = fetch_hwlp_q;

        unique case (state_q)
            StIdle: issue = req_i && (redir || space_idle);
            StWaitGnt: issue = 1'b1;
            StWaitRvalid: begin
                next_addr = fetch_addr_q + 32'd4;
                next_hwlp = 1'b0;
                if (instr_rvalid_i) begin
                    push    = !redir;
                    issue   = req_i && (redir || space_b2b);
                    state_d = StIdle;
                end else if (redir) begin
                    state_d = StWaitAborted;
                end
            end
            StWaitAborted: begin
                if (instr_rvalid_i) begin
                    issue   = req_i;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (redir) begin
            next_addr = redir_addr;
            next_hwlp = redir_hwlp;
        end

        // Reset must silence the request even though the idle request path is combinational.
        issue = issue && rst_n;

        if (issue) begin
            state_d      = instr_gnt_i ? StWaitRvalid : StWaitGnt;
            fetch_addr_d = next_addr;
            fetch_hwlp_d = next_hwlp;
        end else if (redir || (state_q == StWaitRvalid && instr_rvalid_i)) begin
            fetch_addr_d = next_addr;
            fetch_hwlp_d = next_hwlp;
        end
    end

    assign instr_req_o  = issue;
    assign instr_addr_o = next_addr;

    always_comb begin
        count_d = count_q;
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        if (redir) begin
            count_d = '0;
            rptr_d  = '0;
            wptr_d  = '0;
        end else begin
            if (push) begin
                wptr_d = (wptr_q == PtrW'(DEPTH - 1)) ? '0 : wptr_q + PtrW'(1);
            end
            if (pop) begin
                rptr_d = (rptr_q == PtrW'(DEPTH - 1)) ? '0 : rptr_q + PtrW'(1);
            end
            count_d = count_q + CntW'(push) - CntW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            fetch_addr_q <= '0;
            fetch_hwlp_q <= 1'b0;
            count_q      <= '0;
            rptr_q       <= '0;
            wptr_q       <= '0;
            mem_rdata_q  <= '0;
            mem_addr_q   <= '0;
            mem_hwlp_q   <= '0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            fetch_hwlp_q <= fetch_hwlp_d;
            count_q      <= count_d;
            rptr_q       <= rptr_d;
            wptr_q       <= wptr_d;
            if (push) begin
                mem_rdata_q[wptr_q] <= instr_rdata_i;
                mem_addr_q[wptr_q]  <= fetch_addr_q;
                mem_hwlp_q[wptr_q]  <= fetch_hwlp_q;
            end
        end
    end

endmodule

// File: tb/tb_riscv_fetch_queue.sv
// tb_riscv_fetch_queue: directed bench for riscv_fetch_queue (DEPTH = 3).
// A small memory responder returns word (addr ^ 32'h5A5A_0000) rv_lat cycles after a grant.
module tb_riscv_fetch_queue;

    logic        clk;
    logic        rst_n;
    logic        req_i;
    logic        branch_i;
    logic [31:0] addr_i;
    logic        hwloop_i;
    logic [31:0] hwloop_target_i;
    logic        ready_i;
    logic        valid_o;
    logic [31:0] rdata_o;
    logic [31:0] addr_o;
    logic        is_hwlp_o;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic        busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Responder controls
    int          rv_lat    = 1;
    int          stray_req = 0;
    int          stray_ack = 0;
    bit          rv_pend;
    int          rv_wait;
    logic [31:0] rv_addr;
    bit          gnt_now;
    logic [31:0] gnt_addr;

    riscv_fetch_queue #(.DEPTH(3)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_i           (req_i),
        .branch_i        (branch_i),
        .addr_i          (addr_i),
        .hwloop_i        (hwloop_i),
        .hwloop_target_i (hwloop_target_i),
        .ready_i         (ready_i),
        .valid_o         (valid_o),
        .rdata_o         (rdata_o),
        .addr_o          (addr_o),
        .is_hwlp_o       (is_hwlp_o),
        .instr_req_o     (instr_req_o),
        .instr_addr_o    (instr_addr_o),
        .instr_gnt_i     (instr_gnt_i),
        .instr_rvalid_i  (instr_rvalid_i),
        .instr_rdata_i   (instr_rdata_i),
        .busy_o          (busy_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // Memory responder: grant sampled just before each rising edge, rvalid driven just after.
    initial begin
        instr_rvalid_i = 1'b0;
        instr_rdata_i  = '0;
        rv_pend        = 1'b0;
        rv_wait        = 0;
        forever begin
            @(negedge clk);
            #4;
            gnt_now  = rst_n && instr_req_o && instr_gnt_i;
            gnt_addr = instr_addr_o;
            @(posedge clk);
            #1;
            instr_rvalid_i = 1'b0;
            if (!rst_n) rv_pend = 1'b0;
            if (rv_pend) begin
                rv_wait--;
                if (rv_wait == 0) begin
                    instr_rvalid_i = 1'b1;
                    instr_rdata_i  = mem_word(rv_addr);
                    rv_pend        = 1'b0;
                end
            end
            if (gnt_now) begin
                rv_addr = gnt_addr;
                rv_wait = rv_lat - 1;
                rv_pend = 1'b1;
                if (rv_wait == 0) begin
                    instr_rvalid_i = 1'b1;
                    instr_rdata_i  = mem_word(rv_addr);
                    rv_pend        = 1'b0;
                end
            end
            if (stray_req != stray_ack) begin
                instr_rvalid_i = 1'b1;
                instr_rdata_i  = 32'hBAD0_BAD0;
                stray_ack      = stray_req;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic test_reset();
        rst_n = 1'b0; req_i = 1'b1; branch_i = 1'b0; addr_i = '0; hwloop_i = 1'b0;
        hwloop_target_i = '0; ready_i = 1'b0; instr_gnt_i = 1'b1;
        #1;
        n_checks++; if (instr_req_o !== 1'b0) begin n_fail++;
            $display("FAIL reset_req: got %b want 0", instr_req_o); end
        @(negedge clk); #1;
        n_checks++; if (valid_o !== 1'b0) begin n_fail++;
            $display("FAIL reset_valid: got %b want 0", valid_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++;
            $display("FAIL reset_busy: got %b want 0", busy_o); end
        n_checks++; if (rdata_o !== 32'h0 || addr_o !== 32'h0 || is_hwlp_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_head: got rdata %h addr %h hwlp %b want zeros",
                               rdata_o, addr_o, is_hwlp_o); end
        req_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Branch to 0x100, then sequential fill until the 3-entry FIFO is full, then drain.
    task automatic test_branch_fill();
        logic [31:0] exp_a [3];
        exp_a = '{32'h100, 32'h104, 32'h108};
        rv_lat = 1; instr_gnt_i = 1'b1; ready_i = 1'b0;
        @(negedge clk);
        req_i = 1'b1; branch_i = 1'b1; addr_i = 32'h0000_0102;
        #1;
        n_checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h100) begin n_fail++;
            $display("FAIL branch_req: got req %b addr %h want 1 00000100",
                     instr_req_o, instr_addr_o); end
        @(negedge clk); branch_i = 1'b0; #1;
        n_checks++; if (valid_o !== 1'b0) begin n_fail++;
            $display("FAIL no_bypass: got valid %b want 0", valid_o); end
        n_checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h104) begin n_fail++;
            $display("FAIL b2b_req: got req %b addr %h want 1 00000104",
                     instr_req_o, instr_addr_o); end
        @(negedge clk); #1;
        n_checks++; if (valid_o !== 1'b1 || addr_o !== 32'h100 || rdata_o !== 32'h5A5A_0100)
            begin n_fail++; $display("FAIL first_entry: got valid %b addr %h rdata %h",
                                     valid_o, addr_o, rdata_o); end
        n_checks++; if (instr_addr_o !== 32'h108) begin n_fail++;
            $display("FAIL seq_addr: got %h want 00000108", instr_addr_o); end
        @(negedge clk); #1;
        n_checks++; if (instr_req_o !== 1'b0) begin n_fail++;
            $display("FAIL full_stop_b2b: got req %b want 0", instr_req_o); end
        @(negedge clk); #1;
        n_checks++; if (instr_req_o !== 1'b0 || busy_o !== 1'b1) begin n_fail++;
            $display("FAIL full_idle: got req %b busy %b want 0 1", instr_req_o, busy_o); end
        req_i = 1'b0; ready_i = 1'b1; #1;
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (valid_o !== 1'b1 || addr_o !== exp_a[k] ||
                            rdata_o !== (exp_a[k] ^ 32'h5A5A_0000)) begin n_fail++;
                $display("FAIL drain_%0d: got valid %b addr %h rdata %h want addr %h",
                         k, valid_o, addr_o, rdata_o, exp_a[k]); end
            @(negedge clk); #1;
        end
        ready_i = 1'b0;
        n_checks++; if (valid_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++;
            $display("FAIL drained: got valid %b busy %b want 0 0", valid_o, busy_o); end
    endtask

    // Branch while waiting for 0x104 data: that data must never show up.
    task automatic test_branch_abort();
        rv_lat = 2; instr_gnt_i = 1'b1; ready_i = 1'b0;
        @(negedge clk);
        req_i = 1'b1; branch_i = 1'b1; addr_i = 32'h104; #1;
        n_checks++; if (instr_addr_o !== 32'h104) begin n_fail++;
            $display("FAIL abort_first_addr: got %h want 00000104", instr_addr_o); end
        @(negedge clk); addr_i = 32'h200; #1;
        n_checks++; if (instr_req_o !== 1'b0) begin n_fail++;
            $display("FAIL single_outstanding: got req %b want 0", instr_req_o); end
        @(negedge clk); branch_i = 1'b0; #1;
        n_checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h200) begin n_fail++;
            $display("FAIL aborted_reissue: got req %b addr %h want 1 00000200",
                     instr_req_o, instr_addr_o); end
        n_checks++; if (valid_o !== 1'b0) begin n_fail++;
            $display("FAIL aborted_valid0: got %b want 0", valid_o); end
        @(negedge clk); #1;
        n_checks++; if (valid_o !== 1'b0) begin n_fail++;
            $display("FAIL aborted_drop: got %b want 0", valid_o); end
        @(negedge clk); req_i = 1'b0; #1;
        n_checks++; if (valid_o !== 1'b0 || instr_req_o !== 1'b0) begin n_fail++;
            $display("FAIL aborted_wait: got valid %b req %b want 0 0", valid_o, instr_req_o); end
        @(negedge clk); #1;
        n_checks++; if (valid_o !== 1'b1 || addr_o !== 32'h200 || rdata_o !== 32'h5A5A_0200)
            begin n_fail++; $display("FAIL target_entry: got valid %b addr %h rdata %h",
                                     valid_o, addr_o, rdata_o); end
        branch_i = 1'b1; addr_i = 32'h300; #1;
        n_checks++; if (valid_o !== 1'b0) begin n_fail++;
            $display("FAIL flush_mask: got valid %b want 0", valid_o); end
        @(negedge clk); branch_i = 1'b0; #1;
        n_checks++; if (valid_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++;
            $display("FAIL flush_after: got valid %b busy %b want 0 0", valid_o, busy_o); end
    endtask

    task automatic test_hwloop();
        rv_lat = 1; instr_gnt_i = 1'b1; ready_i = 1'b0;
        @(negedge clk);
        req_i = 1'b1; branch_i = 1'b1; addr_i = 32'h120; #1;
        @(negedge clk); branch_i = 1'b0; #1;
        @(negedge clk); #1;
        n_checks++; if (valid_o !== 1'b1 || addr_o !== 32'h120 || is_hwlp_o !== 1'b0) begin
            n_fail++; $display("FAIL hwlp_head: got valid %b addr %h hwlp %b",
                               valid_o, addr_o, is_hwlp_o); end
        hwloop_i = 1'b1; hwloop_target_i = 32'h100; ready_i = 1'b1; #1;
        n_checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h100) begin n_fail++;
            $display("FAIL hwlp_redirect: got req %b addr %h want 1 00000100",
                     instr_req_o, instr_addr_o); end
        @(negedge clk); hwloop_i = 1'b0; ready_i = 1'b0; #1;
        n_checks++; if (valid_o !== 1'b0 || instr_addr_o !== 32'h104) begin n_fail++;
            $display("FAIL hwlp_flush: got valid %b next addr %h want 0 00000104",
                     valid_o, instr_addr_o); end
        @(negedge clk); ready_i = 1'b1; req_i = 1'b0; #1;
        n_checks++; if (valid_o !== 1'b1 || addr_o !== 32'h100 || is_hwlp_o !== 1'b1 ||
                        rdata_o !== 32'h5A5A_0100) begin n_fail++;
            $display("FAIL hwlp_target: got valid %b addr %h hwlp %b rdata %h",
                     valid_o, addr_o, is_hwlp_o, rdata_o); end
        @(negedge clk); #1;
        n_checks++; if (valid_o !== 1'b1 || addr_o !== 32'h104 || is_hwlp_o !== 1'b0) begin
            n_fail++; $display("FAIL hwlp_follow: got valid %b addr %h hwlp %b want 1 104 0",
                               valid_o, addr_o, is_hwlp_o); end
        @(negedge clk); ready_i = 1'b0; #1;
        n_checks++; if (valid_o !== 1'b0) begin n_fail++;
            $display("FAIL hwlp_empty: got valid %b want 0", valid_o); end
    endtask

    task automatic test_wrap();
        rv_lat = 1; instr_gnt_i = 1'b1; ready_i = 1'b0;
        @(negedge clk);
        req_i = 1'b1; branch_i = 1'b1; addr_i = 32'hFFFF_FFFF; #1;
        n_checks++; if (instr_addr_o !== 32'hFFFF_FFFC) begin n_fail++;
            $display("FAIL align: got %h want fffffffc", instr_addr_o); end
        @(negedge clk); branch_i = 1'b0; #1;
        n_checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h0) begin n_fail++;
            $display("FAIL wrap_addr: got req %b addr %h want 1 00000000",
                     instr_req_o, instr_addr_o); end
        @(negedge clk); req_i = 1'b0; #1;
        @(negedge clk); #1;
        n_checks++; if (valid_o !== 1'b1 || addr_o !== 32'hFFFF_FFFC ||
                        rdata_o !== 32'hA5A5_FFFC) begin n_fail++;
            $display("FAIL wrap_e0: got valid %b addr %h rdata %h", valid_o, addr_o, rdata_o); end
        ready_i = 1'b1;
        @(negedge clk); #1;
        n_checks++; if (valid_o !== 1'b1 || addr_o !== 32'h0 || rdata_o !== 32'h5A5A_0000)
            begin n_fail++; $display("FAIL wrap_e1: got valid %b addr %h rdata %h",
                                     valid_o, addr_o, rdata_o); end
        @(negedge clk); ready_i = 1'b0; #1;
        n_checks++; if (valid_o !== 1'b0) begin n_fail++;
            $display("FAIL wrap_empty: got valid %b want 0", valid_o); end
    endtask

    task automatic test_reset_wait_gnt();
        instr_gnt_i = 1'b0; ready_i = 1'b0;
        @(negedge clk);
        req_i = 1'b1; branch_i = 1'b1; addr_i = 32'h400; #1;
        @(negedge clk); branch_i = 1'b0; #1;
        n_checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h400 || busy_o !== 1'b1)
            begin n_fail++; $display("FAIL wait_gnt_hold: got req %b addr %h busy %b",
                                     instr_req_o, instr_addr_o, busy_o); end
        @(negedge clk); branch_i = 1'b1; addr_i = 32'h500; #1;
        n_checks++; if (instr_addr_o !== 32'h500) begin n_fail++;
            $display("FAIL wait_gnt_branch: got %h want 00000500", instr_addr_o); end
        @(negedge clk); branch_i = 1'b0; #1;
        n_checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h500) begin n_fail++;
            $display("FAIL wait_gnt_stable: got req %b addr %h want 1 00000500",
                     instr_req_o, instr_addr_o); end
        rst_n = 1'b0; #1;
        n_checks++; if (instr_req_o !== 1'b0 || valid_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: got req %b valid %b busy %b want 0 0 0",
                               instr_req_o, valid_o, busy_o); end
        @(negedge clk);
        rst_n = 1'b1; req_i = 1'b0; stray_req++;
        @(negedge clk); #1;
        n_checks++; if (valid_o !== 1'b0) begin n_fail++;
            $display("FAIL stray_during: got valid %b want 0", valid_o); end
        @(negedge clk); #1;
        n_checks++; if (valid_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++;
            $display("FAIL stray_after: got valid %b busy %b want 0 0", valid_o, busy_o); end
    endtask

    initial begin
        test_reset();
        test_branch_fill();
        test_branch_abort();
        test_hwloop();
        test_wrap();
        test_reset_wait_gnt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_fetch_queue.md
RISCV_FETCH_QUEUE -- requirements
Module: riscv_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 3, meaning FIFO entries (range 2..4).
REQ-002 SHALL have ports, in this order:
- clk  in  1  clock; rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- req_i  in  1  fetch enable from the IF stage.
- branch_i  in  1  redirect the fetch stream to addr_i.
- addr_i  in  32  branch target.
- hwloop_i  in  1  the head instruction is the last instruction of a hardware loop.
- hwloop_target_i  in  32  loop start address.
- ready_i  in  1  consumer accepts the head entry.
- valid_o  out  1  head entry is valid.
- rdata_o  out  32  head instruction word.
- addr_o  out  32  head instruction address.
- is_hwlp_o  out  1  head entry is a loop-start refetch.
- instr_req_o  out  1  memory request.
- instr_addr_o  out  32  memory address.
- instr_gnt_i  in  1  memory grant.
- instr_rvalid_i  in  1  memory response valid.
- instr_rdata_i  in  32  memory response data.
- busy_o  out  1  FIFO non-empty or request outstanding.

Function
REQ-003 SHALL fetch 32-bit words only; instr_addr_o[1:0] SHALL be 2'b00 and addr_i[1:0] SHALL be ignored.
REQ-004 SHALL allow at most 1 granted-but-unanswered request.
REQ-005 SHALL implement FSM states:
- IDLE
- WAIT_GNT: req high, no grant yet.
- WAIT_RVALID: granted, awaiting data.
- WAIT_ABORTED: granted request belongs to a flushed stream.
REQ-006 IDLE: SHALL assert instr_req_o combinationally when req_i && (branch_i || space); space = (FIFO count + outstanding) < DEPTH.
- gnt in the same cycle -> WAIT_RVALID; otherwise -> WAIT_GNT.
REQ-007 WAIT_GNT: SHALL hold instr_req_o=1.
- instr_addr_o SHALL stay stable unless branch_i or a hwloop redirect occurs; in that case it SHALL change to the new target.
- gnt -> WAIT_RVALID.
REQ-008 WAIT_RVALID: on instr_rvalid_i, SHALL write {instr_rdata_i, request address, hwlp flag} into the FIFO tail.
- In the same cycle SHALL issue the next request if space and req_i (back-to-back), else -> IDLE.
REQ-009 Sequential fetch address SHALL be the last granted address + 4, 32-bit wrap modulo 2^32 (0xFFFFFFFC -> 0x00000000).
REQ-010 Branch: branch_i SHALL flush all FIFO entries in the same cycle; valid_o SHALL be 0 in the cycle after.
- Branch in IDLE or WAIT_GNT: SHALL request addr_i in the same cycle.
- Branch in WAIT_RVALID without rvalid: -> WAIT_ABORTED and SHALL register addr_i.
- Branch in WAIT_RVALID with rvalid: SHALL discard the data and request addr_i in the same cycle.
REQ-011 WAIT_ABORTED: SHALL drop the arriving rvalid data (never write it to the FIFO).
- SHALL issue the request to the saved target in the rvalid cycle.
- A further branch_i SHALL overwrite the saved target.
REQ-012 Hwloop: when valid_o && ready_i && hwloop_i, SHALL pop the head and flush all remaining entries.
- SHALL redirect to hwloop_target_i with the same abort rules as a branch.
- The first word returned from hwloop_target_i SHALL carry is_hwlp_o=1; all others 0.
REQ-013 branch_i SHALL take priority over a simultaneous hwloop redirect.
REQ-014 Read side: valid_o = FIFO non-empty && !branch-flush; the FIFO SHALL pop on valid_o && ready_i.
REQ-015 FIFO push/pop timing:
- Push and pop in the same cycle SHALL be legal when full (count unchanged).
- Data written on an rvalid edge SHALL appear on valid_o no earlier than the next cycle (no bypass).
- FIFO full SHALL block new requests only, never an outstanding rvalid.
REQ-016 With req_i=0, SHALL issue no new request; an outstanding response SHALL still be accepted or dropped per state.
REQ-017 busy_o = (state != IDLE) || FIFO non-empty.
REQ-018 rdata_o, addr_o and is_hwlp_o SHALL be driven from the head entry and are don't-care when valid_o=0.

Reset
REQ-019 On rst_n=0, SHALL asynchronously clear:
- state to IDLE
- FIFO count, pointers and entries to 0
- saved target and fetch address to 0
- instr_req_o=0, valid_o=0, busy_o=0, is_hwlp_o=0, rdata_o=0, addr_o=0.
REQ-020 Reset asserted with a request outstanding SHALL discard it; an rvalid arriving after reset release in IDLE SHALL be ignored.

Verification
REQ-021 Scenario: branch_i with addr_i=0x100, gnt same cycle, rvalid +1 cycle -> valid_o=1 at +2 with addr_o=0x100; next request address 0x104.
REQ-022 Scenario: gnt always 1, rvalid 1 cycle later, ready_i=0 -> exactly 3 entries (0x100,0x104,0x108), then instr_req_o=0 and busy_o=1.
REQ-023 Scenario: branch to 0x200 while in WAIT_RVALID for 0x104 -> 0x104 data never appears; first valid_o shows addr_o=0x200.
REQ-024 Scenario: head 0x120 with hwloop_i=1, target 0x100, ready_i=1 -> next delivered entry addr_o=0x100 with is_hwlp_o=1; following entry 0x104 with is_hwlp_o=0.
REQ-025 Scenario: fetch at 0xFFFFFFFC -> next instr_addr_o=0x00000000.
REQ-026 Scenario: rst_n low while in WAIT_GNT -> instr_req_o=0 and valid_o=0 immediately; a stray rvalid after release does not set valid_o.
